// File: rtl/apa102_frame_rx.sv
// APA102 serial stream receiver: resynchronises led_clk/led_data, finds the start frame and
// decodes LED frames onto a valid/ready pixel port. Optional idle abort: APA102_RX_TIMEOUT_EN.
module apa102_frame_rx #(
  parameter int NUM_LEDS = 64,
  parameter int SOF_BITS = 32,
  parameter int TIMEOUT  = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_clk_in,
  input  logic       led_data_in,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [5:0] pix_index,
  output logic [4:0] pix_bright,
  output logic [7:0] pix_blue,
  output logic [7:0] pix_green,
  output logic [7:0] pix_red,
  output logic       frame_done,
  output logic       hdr_err,
  output logic       overrun,
  output logic       timeout,
  output logic       busy
);

  localparam logic [1:0] S_HUNT     = 2'd0;
  localparam logic [1:0] S_SOF_WAIT = 2'd1;
  localparam logic [1:0] S_LED      = 2'd2;

  localparam int              ZW       = $clog2(SOF_BITS + 1);
  localparam logic [ZW-1:0]   SOF_LAST = ZW'(SOF_BITS - 1);
  localparam logic [6:0]      LED_LAST = 7'(NUM_LEDS - 1);

  logic          led_clk_p0, led_clk_p1, led_clk_p2;
  logic          led_data_p0, led_data_p1;
  logic          strobe, bit_in;
  logic [1:0]    state;
  logic [ZW-1:0] zero_cnt;
  logic [4:0]    bit_cnt;
  logic [6:0]    led_cnt;
  logic [27:0]   shift_reg;
  logic [28:0]   pix_word;
  logic          in_led, capture, hdr_bad, idle_hit, load;

  // Stage p0/p1: two-flop synchronisers; p2 keeps the previous synced clock for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      led_clk_p0  <= 1'b0;
      led_clk_p1  <= 1'b0;
      led_clk_p2  <= 1'b0;
      led_data_p0 <= 1'b0;
      led_data_p1 <= 1'b0;
    end else begin
      led_clk_p0  <= led_clk_in;
      led_clk_p1  <= led_clk_p0;
      led_clk_p2  <= led_clk_p1;
      led_data_p0 <= led_data_in;
      led_data_p1 <= led_data_p0;
    end
  end

  assign strobe   = led_clk_p2 & ~led_clk_p1;
  assign bit_in   = led_data_p1;
  assign in_led   = (state == S_LED);
  assign busy     = (state != S_HUNT);
  // Low 29 frame bits as they stand with the current bit appended; [2:0] is the header at bit_cnt==2
  assign pix_word = {shift_reg, bit_in};
  assign capture  = strobe && in_led && (bit_cnt == 5'd31);
  assign hdr_bad  = strobe && in_led && (bit_cnt == 5'd2) && (pix_word[2:0] != 3'b111);
  assign load     = capture && (!pix_valid || pix_ready);

`ifdef APA102_RX_TIMEOUT_EN
  logic [9:0] idle_cnt;

  assign idle_hit = busy && !strobe && (idle_cnt == 10'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || strobe || !busy || idle_hit) idle_cnt <= 10'd0;
    else                                      idle_cnt <= idle_cnt + 10'd1;
  end
`else
  // Never true: without the idle counter TIMEOUT has no effect
  assign idle_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk) begin
    if (strobe) shift_reg <= {shift_reg[26:0], bit_in};
  end

  // Stage p3: framing FSM, advanced once per bit strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_HUNT;
      zero_cnt <= '0;
      bit_cnt  <= 5'd0;
      led_cnt  <= 7'd0;
    end else if (idle_hit) begin
      state    <= S_HUNT;
      zero_cnt <= '0;
      bit_cnt  <= 5'd0;
    end else if (strobe) begin
      case (state)
        S_HUNT: begin
          if (bit_in) begin
            zero_cnt <= '0;
          end else if (zero_cnt == SOF_LAST) begin
            zero_cnt <= '0;
            state    <= S_SOF_WAIT;
          end else begin
            zero_cnt <= zero_cnt + 1'b1;
          end
        end
        S_SOF_WAIT: begin
          if (bit_in) begin
            bit_cnt <= 5'd1;
            led_cnt <= 7'd0;
            state   <= S_LED;
          end
        end
        S_LED: begin
          if (hdr_bad) begin
            state    <= S_HUNT;
            zero_cnt <= '0;
            bit_cnt  <= 5'd0;
          end else if (bit_cnt == 5'd31) begin
            bit_cnt <= 5'd0;
            led_cnt <= led_cnt + 7'd1;
            // Trailing end-frame zeros are counted as the next start frame
            if (led_cnt == LED_LAST) begin
              state    <= S_HUNT;
              zero_cnt <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

  // Stage p4: pixel output register and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_valid  <= 1'b0;
      pix_index  <= 6'd0;
      pix_bright <= 5'd0;
      pix_blue   <= 8'd0;
      pix_green  <= 8'd0;
      pix_red    <= 8'd0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      hdr_err    <= hdr_bad;
      timeout    <= idle_hit;
      if (load) begin
        pix_valid  <= 1'b1;
        pix_index  <= led_cnt[5:0];
        pix_bright <= pix_word[28:24];
        pix_blue   <= pix_word[23:16];
        pix_green  <= pix_word[15:8];
        pix_red    <= pix_word[7:0];
        frame_done <= (led_cnt == LED_LAST);
      end else begin
        if (capture)   overrun   <= 1'b1;
        if (pix_ready) pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apa102_frame_rx.sv
// Self-checking bench for apa102_frame_rx: random LED streams against a bit-list parsing model.
module tb_apa102_frame_rx;

  localparam int NUM_LEDS = 64;
  localparam int SOF_BITS = 32;
  localparam int TIMEOUT  = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       led_clk_in = 1'b0;
  logic       led_data_in = 1'b0;
  logic       pix_ready = 1'b1;
  logic       pix_valid;
  logic [5:0] pix_index;
  logic [4:0] pix_bright;
  logic [7:0] pix_blue, pix_green, pix_red;
  logic       frame_done, hdr_err, overrun, timeout, busy;

  always #5 clk = ~clk;

  apa102_frame_rx #(.NUM_LEDS(NUM_LEDS), .SOF_BITS(SOF_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .led_clk_in(led_clk_in), .led_data_in(led_data_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index),
    .pix_bright(pix_bright), .pix_blue(pix_blue), .pix_green(pix_green), .pix_red(pix_red),
    .frame_done(frame_done), .hdr_err(hdr_err), .overrun(overrun), .timeout(timeout),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Observed pixels and pulse counts, sampled on the falling clock edge
  logic [34:0] obs_q[$];
  int n_done = 0, n_hdr = 0, n_ovr = 0, n_to = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid && pix_ready) obs_q.push_back({pix_index, pix_bright, pix_blue, pix_green, pix_red});
      if (frame_done) n_done++;
      if (hdr_err)    n_hdr++;
      if (overrun)    n_ovr++;
      if (timeout)    n_to++;
    end
  end

  bit          sq[$];
  logic [34:0] exp_q[$];
  int          exp_hdr;

  function automatic logic [34:0] obs_at(input int k);
    if (k < obs_q.size()) return obs_q[k];
    return 'x;
  endfunction

  function automatic logic [31:0] rand_px();
    return {3'b111, 29'($urandom)};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    led_clk_in = 1'b0;
    led_data_in = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 31; b >= 0; b--) sq.push_back(w[b]);
  endtask

  task automatic push_zeros(input int n);
    repeat (n) sq.push_back(1'b0);
  endtask

  task automatic send_bit(input bit b);
    led_data_in = b;
    led_clk_in = 1'b1;
    tick(int'($urandom_range(2, 1)));
    led_clk_in = 1'b0;
    tick(int'($urandom_range(2, 1)));
  endtask

  task automatic send_bits();
    for (int i = 0; i < sq.size(); i++) send_bit(sq[i]);
  endtask

  // Reference: scan the bit list for a run of SOF_BITS zeros, skip further zeros, then cut
  // 32-bit words; a bad header discards the word after its 3rd bit and resumes the hunt.
  task automatic model_stream();
    int i;
    int n;
    int run;
    logic [31:0] w;
    i = 0;
    n = sq.size();
    exp_q.delete();
    exp_hdr = 0;
    while (i < n) begin
      run = 0;
      while (i < n && run < SOF_BITS) begin
        run = (sq[i] == 1'b0) ? run + 1 : 0;
        i++;
      end
      if (run < SOF_BITS) break;
      while (i < n && sq[i] == 1'b0) i++;
      for (int led = 0; led < NUM_LEDS; led++) begin
        if (i + 3 > n) begin
          i = n;
          break;
        end
        if (!(sq[i] && sq[i+1] && sq[i+2])) begin
          exp_hdr++;
          i += 3;
          break;
        end
        if (i + 32 > n) begin
          i = n;
          break;
        end
        w = '0;
        for (int b = 0; b < 32; b++) w = {w[30:0], sq[i+b]};
        exp_q.push_back({6'(led), w[28:0]});
        i += 32;
      end
    end
  endtask

  task automatic check_stream(input string name, input int ob, input int hb, input int db);
    int exp_done;
    exp_done = 0;
    foreach (exp_q[k]) if (exp_q[k][34:29] == 6'(NUM_LEDS - 1)) exp_done++;
    n_cmp++;
    if (obs_q.size() - ob !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s pixel count: got %0d expected %0d", name, obs_q.size() - ob, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      n_cmp++;
      if (obs_at(ob + k) !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s pixel %0d: got %h expected %h", name, k, obs_at(ob + k), exp_q[k]);
      end
    end
    n_cmp++;
    if (n_hdr - hb !== exp_hdr) begin
      n_fail++;
      $display("FAIL %s hdr_err count: got %0d expected %0d", name, n_hdr - hb, exp_hdr);
    end
    n_cmp++;
    if (n_done - db !== exp_done) begin
      n_fail++;
      $display("FAIL %s frame_done count: got %0d expected %0d", name, n_done - db, exp_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    @(negedge clk);
    n_cmp++;
    if (pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset pix_valid: got %b expected 0", pix_valid);
    end
    n_cmp++;
    if ({pix_index, pix_bright, pix_blue, pix_green, pix_red} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset fields: got %h expected 0", {pix_index, pix_bright, pix_blue, pix_green, pix_red});
    end
    n_cmp++;
    if ({frame_done, hdr_err, overrun, timeout, busy} !== 5'd0) begin
      n_fail++;
      $display("FAIL reset status: got %b expected 00000", {frame_done, hdr_err, overrun, timeout, busy});
    end
    tick(1);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int ob, hb, db;
    do_reset();
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    push_zeros(32);
    repeat (NUM_LEDS) push_word(32'hF0000F00);
    push_zeros(64);
    model_stream();
    send_bits();
    tick(8);
    check_stream("basic", ob, hb, db);
    n_cmp++;
    if (obs_at(ob + 63) !== {6'd63, 5'd16, 8'h00, 8'h0F, 8'h00}) begin
      n_fail++;
      $display("FAIL basic last pixel: got %h expected %h", obs_at(ob + 63), {6'd63, 5'd16, 8'h00, 8'h0F, 8'h00});
    end
    n_cmp++;
    if (n_done - db !== 1) begin
      n_fail++;
      $display("FAIL basic frame_done: got %0d expected 1", n_done - db);
    end
  endtask

  task automatic test_hdr_err();
    int ob, hb, db;
    do_reset();
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    push_zeros(32);
    push_word(32'hB0000F00);
    push_zeros(32);
    push_word(32'hF0000700);
    model_stream();
    send_bits();
    tick(8);
    check_stream("hdr_err", ob, hb, db);
    n_cmp++;
    if (n_hdr - hb !== 1) begin
      n_fail++;
      $display("FAIL hdr_err pulses: got %0d expected 1", n_hdr - hb);
    end
    n_cmp++;
    if (obs_at(ob) !== {6'd0, 5'd16, 8'h00, 8'h07, 8'h00}) begin
      n_fail++;
      $display("FAIL hdr_err recovered pixel: got %h expected %h", obs_at(ob), {6'd0, 5'd16, 8'h00, 8'h07, 8'h00});
    end
  endtask

  task automatic test_backpressure();
    int ob, ovb;
    logic [31:0] w0, w1, w2;
    do_reset();
    w0 = rand_px(); w1 = rand_px(); w2 = rand_px();
    ob = obs_q.size(); ovb = n_ovr;
    pix_ready = 1'b0;
    sq.delete();
    push_zeros(32);
    push_word(w0);
    push_word(w1);
    send_bits();
    tick(8);
    n_cmp++;
    if ({pix_valid, pix_index} !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL backpressure held pixel: got valid=%b index=%0d expected valid=1 index=0", pix_valid, pix_index);
    end
    n_cmp++;
    if (n_ovr - ovb !== 1) begin
      n_fail++;
      $display("FAIL backpressure overrun: got %0d expected 1", n_ovr - ovb);
    end
    pix_ready = 1'b1;
    tick(4);
    sq.delete();
    push_word(w2);
    send_bits();
    tick(8);
    n_cmp++;
    if (obs_q.size() - ob !== 2) begin
      n_fail++;
      $display("FAIL backpressure accepted count: got %0d expected 2", obs_q.size() - ob);
    end
    n_cmp++;
    if (obs_at(ob) !== {6'd0, w0[28:0]}) begin
      n_fail++;
      $display("FAIL backpressure first: got %h expected %h", obs_at(ob), {6'd0, w0[28:0]});
    end
    n_cmp++;
    if (obs_at(ob + 1) !== {6'd2, w2[28:0]}) begin
      n_fail++;
      $display("FAIL backpressure second: got %h expected %h", obs_at(ob + 1), {6'd2, w2[28:0]});
    end
  endtask

  task automatic test_reset_midframe();
    int ob, hb, db;
    logic [31:0] w;
    do_reset();
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    push_zeros(32);
    repeat (5) push_word(rand_px());
    w = rand_px();
    for (int b = 31; b >= 16; b--) sq.push_back(w[b]);
    model_stream();
    send_bits();
    tick(4);
    check_stream("pre_reset", ob, hb, db);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pix_valid, pix_index, pix_bright, pix_blue, pix_green, pix_red, frame_done, hdr_err, overrun, timeout, busy} !== 41'd0) begin
      n_fail++;
      $display("FAIL midframe reset outputs: got %h expected 0",
               {pix_valid, pix_index, pix_bright, pix_blue, pix_green, pix_red, frame_done, hdr_err, overrun, timeout, busy});
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick(2);
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    push_zeros(32);
    repeat (NUM_LEDS) push_word(rand_px());
    push_zeros(40);
    model_stream();
    send_bits();
    tick(8);
    check_stream("post_reset", ob, hb, db);
  endtask

  task automatic test_back_to_back();
    int ob, hb, db;
    do_reset();
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    push_zeros(32);
    repeat (NUM_LEDS) push_word(rand_px());
    push_zeros(64);
    repeat (NUM_LEDS) push_word(rand_px());
    push_zeros(64);
    model_stream();
    send_bits();
    tick(8);
    check_stream("back_to_back", ob, hb, db);
    n_cmp++;
    if (obs_q.size() - ob !== 2 * NUM_LEDS) begin
      n_fail++;
      $display("FAIL back_to_back total: got %0d expected %0d", obs_q.size() - ob, 2 * NUM_LEDS);
    end
    n_cmp++;
    if (n_done - db !== 2) begin
      n_fail++;
      $display("FAIL back_to_back frame_done: got %0d expected 2", n_done - db);
    end
  endtask

  task automatic test_random();
    int ob, hb, db;
    do_reset();
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    repeat (20) sq.push_back(1'($urandom));
    push_zeros(int'($urandom_range(48, 32)));
    for (int k = 0; k < NUM_LEDS; k++) begin
      if ($urandom_range(7, 0) == 0) push_word({3'($urandom_range(6, 0)), 29'($urandom)});
      else                           push_word(rand_px());
    end
    push_zeros(40);
    repeat (NUM_LEDS / 2) push_word(rand_px());
    model_stream();
    send_bits();
    tick(8);
    check_stream("random", ob, hb, db);
  endtask

`ifdef APA102_RX_TIMEOUT_EN
  task automatic test_timeout();
    int ob, hb, db, to_b, waited;
    logic [31:0] w;
    do_reset();
    to_b = n_to;
    w = 32'hF0000F00;
    sq.delete();
    push_zeros(32);
    for (int b = 31; b >= 22; b--) sq.push_back(w[b]);
    send_bits();
    waited = 0;
    while (n_to == to_b && waited < 1200) begin
      tick(1);
      waited++;
    end
    n_cmp++;
    if (waited < 1010 || waited > 1030) begin
      n_fail++;
      $display("FAIL timeout delay: got %0d cycles expected about %0d", waited, TIMEOUT);
    end
    tick(1);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout busy: got %b expected 0", busy);
    end
    ob = obs_q.size(); hb = n_hdr; db = n_done;
    sq.delete();
    push_zeros(32);
    push_word(rand_px());
    model_stream();
    send_bits();
    tick(8);
    check_stream("after_timeout", ob, hb, db);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hdr_err();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
`ifdef APA102_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
